// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared constants, FSM states and BCD helper for the digit scanner
package scan_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } scan_state_t;

    function automatic logic [3:0] bcd_adj(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter holding the display register
module bin2bcd_seq
    import scan_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd_packed
);

    localparam int ACC_W = 4 * DIGITS + 4;
    localparam int CNT_W = $clog2(BIN_W);

    scan_state_t          state_q, state_d;
    logic [BIN_W-1:0]     sr_q, sr_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic [4*DIGITS-1:0]  disp_q, disp_d;
    logic                 bad;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        adj     = acc_q;
        bad     = (acc_q[ACC_W-1 -: 4] != 4'd0);
        for (int k = 0; k < DIGITS + 1; k++) begin
            adj[k*4 +: 4] = bcd_adj(acc_q[k*4 +: 4]);
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[k*4 +: 4] > 4'd9) bad = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    sr_d    = bin_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {adj[ACC_W-2:0], sr_q[BIN_W-1]};
                sr_d  = {sr_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) state_d = FINISH;
            end
            FINISH: begin
                // Display register only changes here, so the scan never shows a partial value
                if (bad) begin
                    ovf_d  = 1'b1;
                    disp_d = {DIGITS{BCD_BLANK}};
                end else begin
                    ovf_d  = 1'b0;
                    disp_d = acc_q[4*DIGITS-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ovf        = ovf_q;
    assign bcd_packed = disp_q;

endmodule

// File: rtl/bcd_digit_scanner.sv
// rtl/bcd_digit_scanner.sv - binary-to-BCD display feeder with digit multiplexing and blanking
module bcd_digit_scanner
    import scan_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIN_W-1:0]   bin_in,
    input  logic               load,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic [3:0]         bcd_out,
    output logic [DIGITS-1:0]  an
);

    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] disp;
    logic [RC_W-1:0]     ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          bcd_q, bcd_d;
    logic                zero_above;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_conv (
        .clk        (clk),
        .rst        (rst),
        .bin_in     (bin_in),
        .load       (load),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .bcd_packed (disp)
    );

    always_comb begin
        ref_cnt_d = ref_cnt_q + RC_W'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == RC_W'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            idx_d     = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        // an and bcd_out both derive from the same idx_q, so they switch together
        an_d       = ~(DIGITS'(1) << idx_q);
        bcd_d      = 4'h0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp[k*4 +: 4] == 4'h0);
            if (idx_q == IDX_W'(k)) begin
                bcd_d = ((LZ_BLANK != 0) && (k != 0) && zero_above) ? BCD_BLANK : disp[k*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
            an_q      <= ~DIGITS'(1);
            bcd_q     <= 4'h0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
        end
    end

    assign an      = an_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb/tb_bcd_digit_scanner.sv - randomized self-checking bench against a decimal reference model
module tb_bcd_digit_scanner;

    localparam int DIGITS      = 4;
    localparam int BIN_W       = 14;
    localparam int REFRESH_DIV = 4;
    localparam int LZ_BLANK    = 1;

    logic               clk;
    logic               rst;
    logic [BIN_W-1:0]   bin_in;
    logic               load;
    logic               busy;
    logic               done;
    logic               ovf;
    logic [3:0]         bcd_out;
    logic [DIGITS-1:0]  an;

    int n_checks;
    int n_errors;

    int m_tick;
    int m_val;
    int m_busy;
    int m_ovf;
    int m_fin_tick;
    int m_pend;
    int done_count;

    bcd_digit_scanner #(
        .DIGITS      (DIGITS),
        .BIN_W       (BIN_W),
        .REFRESH_DIV (REFRESH_DIV),
        .LZ_BLANK    (LZ_BLANK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bin_in  (bin_in),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .bcd_out (bcd_out),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_digit(input int k, input int val, input int is_ovf);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (is_ovf != 0) return 4'hF;
        if (LZ_BLANK != 0 && k > 0 && val < p) return 4'hF;
        return 4'((val / p) % 10);
    endfunction

    always @(posedge clk) begin
        logic r, l;
        int b, slot, exp_done;
        logic [3:0] exp_bcd;
        logic [DIGITS-1:0] exp_an;
        r = rst;
        l = load;
        b = int'(bin_in);
        exp_done = 0;
        if (r) begin
            m_tick = 0; m_val = 0; m_busy = 0; m_ovf = 0;
            exp_an = ~DIGITS'(1);
            exp_bcd = 4'h0;
        end else begin
            slot = (m_tick / REFRESH_DIV) % DIGITS;
            exp_an = ~(DIGITS'(1) << slot);
            exp_bcd = exp_digit(slot, m_val, m_ovf);
            m_tick++;
            if (m_busy != 0 && m_tick == m_fin_tick) begin
                m_busy = 0;
                exp_done = 1;
                if (m_pend > 9999) begin
                    m_ovf = 1;
                end else begin
                    m_ovf = 0;
                    m_val = m_pend;
                end
            end else if (m_busy == 0 && l) begin
                m_busy = 1;
                m_fin_tick = m_tick + BIN_W + 1;
                m_pend = b;
            end
        end
        #1;
        if (done === 1'b1) done_count++;
        check("busy", busy, m_busy);
        check("done", done, exp_done);
        check("ovf", ovf, m_ovf);
        check("an", an, exp_an);
        check("bcd_out", bcd_out, exp_bcd);
    end

    task automatic do_load(input int v);
        @(negedge clk);
        bin_in = BIN_W'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_count = 0;
        rst = 1'b1;
        load = 1'b0;
        bin_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        done_count = 0;
        do_load(1234);
        repeat (40) @(negedge clk);
        check("done_count_1234", done_count, 1);

        do_load(9999);
        repeat (24) @(negedge clk);
        do_load(10000);
        repeat (24) @(negedge clk);

        done_count = 0;
        do_load(42);
        repeat (4) @(negedge clk);
        bin_in = BIN_W'(7777);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (30) @(negedge clk);
        check("done_count_busy_load", done_count, 1);

        done_count = 0;
        do_load(5678);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("done_count_abort", done_count, 0);

        do_load(7);
        repeat (40) @(negedge clk);

        bin_in = BIN_W'(305);
        load = 1'b1;
        repeat (50) @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst = ($urandom % 97 == 0);
            load = ($urandom % 6 == 0);
            if ($urandom % 3 == 0)
                bin_in = BIN_W'($urandom_range(9990, 16383));
            else
                bin_in = BIN_W'($urandom % 10000);
        end
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
